// File: rtl/work_dispatcher_if.sv
// ---------------------------------------------------------------------------
// work_dispatcher_if
//   Bundle of every non-clock, non-reset signal of work_dispatcher.
//   master : the dispatcher itself.
//   slave  : the surroundings (serial_handler side, hash cores, result sink).
//   Signals:
//     new_work/work_data          work unit in (pulse + 640-bit payload)
//     core_work/core_nonce_base   latched work and per-core start nonce out
//     core_start/core_abort       core control pulses out
//     core_found/core_nonce       per-core hit pulse and hit nonce in
//     core_done                   per-core range finished (level) in
//     result_busy                 downstream back-pressure in
//     new_result/result_data      result strobe and nonce out
//     running/exhausted/dropped   status out
// ---------------------------------------------------------------------------
interface work_dispatcher_if #(
    parameter int NUM_CORES = 4
);
    logic                      new_work;
    logic [639:0]              work_data;
    logic [639:0]              core_work;
    logic [32*NUM_CORES-1:0]   core_nonce_base;
    logic [NUM_CORES-1:0]      core_start;
    logic                      core_abort;
    logic [NUM_CORES-1:0]      core_found;
    logic [32*NUM_CORES-1:0]   core_nonce;
    logic [NUM_CORES-1:0]      core_done;
    logic                      result_busy;
    logic                      new_result;
    logic [31:0]               result_data;
    logic                      running;
    logic                      exhausted;
    logic [7:0]                dropped;

    modport master (
        input  new_work, work_data, core_found, core_nonce, core_done, result_busy,
        output core_work, core_nonce_base, core_start, core_abort,
               new_result, result_data, running, exhausted, dropped
    );

    modport slave (
        output new_work, work_data, core_found, core_nonce, core_done, result_busy,
        input  core_work, core_nonce_base, core_start, core_abort,
               new_result, result_data, running, exhausted, dropped
    );
endinterface

// File: rtl/work_dispatcher.sv
// ---------------------------------------------------------------------------
// work_dispatcher
//   Latches a work unit, splits the 32-bit nonce space evenly over NUM_CORES
//   cores, starts them together and aborts/reloads them on new work. Core
//   hits land in one pending slot per core, are moved round-robin into a
//   result FIFO and leave one at a time on new_result/result_data, at most
//   one strobe every two cycles and only while result_busy is low.
//   Ports:
//     clk, rst : system clock, synchronous active-high reset
//     bus      : work_dispatcher_if.master (see interface file)
// ---------------------------------------------------------------------------
module work_dispatcher #(
    parameter int NUM_CORES    = 4,
    parameter int RESULT_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    work_dispatcher_if.master   bus
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(RESULT_DEPTH);
    // Width of one core's share of the nonce space (2^32 / NUM_CORES).
    localparam logic [32:0] RANGE = 33'h1_0000_0000 / 33'(NUM_CORES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                 state;
    logic                   run_armed;
    logic [NUM_CORES-1:0]   slot_vld;
    logic [31:0]            slot_nonce [NUM_CORES];
    logic [IW-1:0]          rr_ptr;
    logic [31:0]            fifo_mem [RESULT_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;

    logic                   accept;
    logic                   fifo_full;
    logic                   pop;
    logic                   grant_vld;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          cand;
    logic [4:0]             drop_cnt;

    function automatic logic [7:0] sat_add_drops(input logic [7:0] cur, input logic [4:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cur} + {4'b0000, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Hits arriving together with new work belong to the stale job.
    assign accept    = ((state == S_RUN) || (state == S_DONE)) && !bus.new_work;
    assign fifo_full = (count == (AW+1)'(RESULT_DEPTH));
    // The previous-strobe term spaces strobes at least two cycles apart.
    assign pop       = (count != '0) && !bus.result_busy && !bus.new_result && !bus.new_work;
    assign bus.core_abort = bus.new_work && (state == S_RUN);

    // Round-robin pick: rr_ptr is the first index searched this cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_CORES);
            if (!grant_vld && slot_vld[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (fifo_full || bus.new_work) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accept && bus.core_found[i] && slot_vld[i]) begin
                drop_cnt = drop_cnt + 5'd1;
            end
        end
    end

    // Control FSM with registered start/running/exhausted outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            run_armed           <= 1'b0;
            bus.core_start      <= '0;
            bus.running         <= 1'b0;
            bus.exhausted       <= 1'b0;
            bus.core_work       <= '0;
            bus.core_nonce_base <= '0;
        end else begin
            bus.core_start <= '0;
            bus.exhausted  <= 1'b0;
            if (bus.new_work) begin
                state         <= S_LOAD;
                bus.running   <= 1'b0;
                bus.core_start <= '1;
                bus.core_work <= bus.work_data;
                for (int i = 0; i < NUM_CORES; i++) begin
                    bus.core_nonce_base[32*i +: 32] <= 32'(RANGE * 33'(i));
                end
            end else begin
                case (state)
                    S_LOAD: begin
                        state       <= S_RUN;
                        bus.running <= 1'b1;
                        run_armed   <= 1'b0;
                    end
                    S_RUN: begin
                        // core_done is ignored in the first RUN cycle so stale
                        // done levels from the previous job cannot end this one.
                        run_armed <= 1'b1;
                        if (run_armed && (&bus.core_done)) begin
                            state         <= S_DONE;
                            bus.running   <= 1'b0;
                            bus.exhausted <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pending slots, round-robin pointer and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld    <= '0;
            rr_ptr      <= '0;
            bus.dropped <= '0;
        end else begin
            bus.dropped <= sat_add_drops(bus.dropped, drop_cnt);
            if (grant_vld) begin
                rr_ptr <= IW'((int'(grant_idx) + 1) % NUM_CORES);
            end
            if (bus.new_work) begin
                slot_vld <= '0;
            end else begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (grant_vld && (grant_idx == IW'(i))) begin
                        slot_vld[i] <= 1'b0;
                    end
                    if (accept && bus.core_found[i] && !slot_vld[i]) begin
                        slot_vld[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accept && bus.core_found[i] && !slot_vld[i]) begin
                slot_nonce[i] <= bus.core_nonce[32*i +: 32];
            end
        end
    end

    // Result FIFO bookkeeping; new work flushes it.
    always_ff @(posedge clk) begin
        if (rst || bus.new_work) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, grant_vld} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            fifo_mem[wr_ptr] <= slot_nonce[grant_idx];
        end
    end

    // Output strobe stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.new_result  <= 1'b0;
            bus.result_data <= '0;
        end else begin
            bus.new_result <= pop;
            if (pop) begin
                bus.result_data <= fifo_mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_work_dispatcher.sv
module tb_work_dispatcher;
    localparam int NC    = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    work_dispatcher_if #(.NUM_CORES(NC)) bus();

    work_dispatcher #(.NUM_CORES(NC), .RESULT_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_strobe = -10;
    logic [31:0] exp_q [$];
    logic [31:0] base_exp [NC] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_running"},     640'(bus.running),         640'(0));
        check({tag, "_new_result"},  640'(bus.new_result),      640'(0));
        check({tag, "_result_data"}, 640'(bus.result_data),     640'(0));
        check({tag, "_core_start"},  640'(bus.core_start),      640'(0));
        check({tag, "_core_abort"},  640'(bus.core_abort),      640'(0));
        check({tag, "_exhausted"},   640'(bus.exhausted),       640'(0));
        check({tag, "_core_work"},   bus.core_work,             640'(0));
        check({tag, "_nonce_base"},  640'(bus.core_nonce_base), 640'(0));
        check({tag, "_dropped"},     640'(bus.dropped),         640'(0));
    endtask

    // Monitor: every strobe is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (bus.new_result === 1'b1) begin
            n_checks++;
            if (cyc - last_strobe < 2) begin
                n_fail++;
                $display("FAIL strobe_spacing: got %0d cycles, expected >= 2", cyc - last_strobe);
            end
            last_strobe = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got %0h, expected no strobe", bus.result_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.result_data !== e) begin
                    n_fail++;
                    $display("FAIL result_data: got %0h, expected %0h", bus.result_data, e);
                end
            end
        end
    end

    initial begin
        int ex_cnt;
        bus.new_work    = 1'b0;
        bus.work_data   = '0;
        bus.core_found  = '0;
        bus.core_nonce  = '0;
        bus.core_done   = '0;
        bus.result_busy = 1'b0;

        // Reset state
        rst = 1'b1;
        step(2);
        check_reset_values("reset");
        rst = 1'b0;
        step(1);

        // Work load from IDLE
        bus.new_work  = 1'b1;
        bus.work_data = {80{8'hA5}};
        #2 check("abort_from_idle", 640'(bus.core_abort), 640'(0));
        step(1);
        bus.new_work = 1'b0;
        check("start_pulse", 640'(bus.core_start), 640'(4'b1111));
        check("core_work_a5", bus.core_work, {80{8'hA5}});
        for (int i = 0; i < NC; i++)
            check($sformatf("nonce_base%0d", i), 640'(bus.core_nonce_base[32*i +: 32]), 640'(base_exp[i]));
        check("running_in_load", 640'(bus.running), 640'(0));
        step(1);
        check("start_one_cycle", 640'(bus.core_start), 640'(0));
        check("running_in_run", 640'(bus.running), 640'(1));

        // Simultaneous hits from cores 0, 1, 3
        step(2);
        bus.core_nonce = {32'h44, 32'h0, 32'h22, 32'h11};
        bus.core_found = 4'b1011;
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h44);
        step(1);
        bus.core_found = '0;
        step(12);
        check("dropped_after_multi", 640'(bus.dropped), 640'(0));
        check("multi_drained", 640'(exp_q.size()), 640'(0));

        // Back-pressure: 12 hits from core 0, 8 queued + 1 pending + 3 dropped
        bus.result_busy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.core_nonce[31:0] = 32'h100 + 32'(k);
            bus.core_found = 4'b0001;
            if (k < 9) exp_q.push_back(32'h100 + 32'(k));
            step(1);
            bus.core_found = '0;
            step(2);
        end
        check("dropped_overflow", 640'(bus.dropped), 640'(3));
        bus.result_busy = 1'b0;
        step(30);
        check("busy_drained", 640'(exp_q.size()), 640'(0));

        // New work during RUN with queued results and a same-cycle hit
        bus.result_busy = 1'b1;
        bus.core_nonce  = {32'h0, 32'h0, 32'h202, 32'h201};
        bus.core_found  = 4'b0011;
        step(1);
        bus.core_found = '0;
        step(4);
        bus.new_work   = 1'b1;
        bus.work_data  = {80{8'h5A}};
        bus.core_nonce = {32'h0, 32'h333, 32'h0, 32'h0};
        bus.core_found = 4'b0100;
        #2 check("abort_from_run", 640'(bus.core_abort), 640'(1));
        step(1);
        bus.new_work    = 1'b0;
        bus.core_found  = '0;
        bus.result_busy = 1'b0;
        check("restart_start", 640'(bus.core_start), 640'(4'b1111));
        check("abort_in_load", 640'(bus.core_abort), 640'(0));
        check("core_work_5a", bus.core_work, {80{8'h5A}});
        step(1);
        check("running_after_abort", 640'(bus.running), 640'(1));
        step(12);
        check("dropped_kept_on_new_work", 640'(bus.dropped), 640'(3));

        // New work while in LOAD restarts LOAD without abort
        bus.new_work  = 1'b1;
        bus.work_data = {80{8'h3C}};
        step(1);
        bus.work_data = {80{8'hC3}};
        #2 check("no_abort_from_load", 640'(bus.core_abort), 640'(0));
        step(1);
        bus.new_work = 1'b0;
        check("reload_start", 640'(bus.core_start), 640'(4'b1111));
        check("core_work_c3", bus.core_work, {80{8'hC3}});
        step(1);
        check("running_after_reload", 640'(bus.running), 640'(1));

        // Range exhaustion
        step(2);
        bus.core_done = '1;
        ex_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (bus.exhausted === 1'b1) ex_cnt++;
        end
        check("exhausted_pulses", 640'(ex_cnt), 640'(1));
        check("running_in_done", 640'(bus.running), 640'(0));
        bus.core_done = '0;
        bus.new_work  = 1'b1;
        bus.work_data = {80{8'h0F}};
        #2 check("no_abort_from_done", 640'(bus.core_abort), 640'(0));
        step(1);
        bus.new_work = 1'b0;
        check("start_from_done", 640'(bus.core_start), 640'(4'b1111));
        step(1);
        check("running_from_done", 640'(bus.running), 640'(1));

        // Reset mid-run with a queued result
        step(2);
        bus.result_busy      = 1'b1;
        bus.core_nonce[31:0] = 32'h500;
        bus.core_found       = 4'b0001;
        step(1);
        bus.core_found = '0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_values("midrun_reset");
        bus.result_busy = 1'b0;
        step(12);
        check("final_queue_empty", 640'(exp_q.size()), 640'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/work_dispatcher.md
# work_dispatcher

Parametrised multi-core work distributor for the miner top level, sitting between `serial_handler` and an array of `NUM_CORES` hash cores. It latches each 80-byte work unit, splits the 32-bit nonce space into equal per-core ranges, starts all cores together, and aborts and reloads them when new work arrives. Core hits are collected through round-robin arbitration into a result FIFO, then presented one at a time on the `new_result`/`result_data` pair, throttled by the downstream busy signal. Unlike the single-core path, it reports range exhaustion and counts dropped results.

## Interface
- `NUM_CORES`, default 4: number of hash cores; power of two, 1..16.
- `RESULT_DEPTH`, default 8: result FIFO depth; power of two, 2..64.
- `clk` in, 1: system clock (50 MHz).
- `rst` in, 1: reset; synchronous, active-high. Single clock domain.
- `new_work` in, 1: one-cycle pulse; `work_data` is valid in the same cycle.
- `work_data` in, 640: 80-byte work unit.
- `core_work` out, 640: latched work, broadcast to all cores.
- `core_nonce_base` out, 32*NUM_CORES: start nonce for core i, in slice [32i+31:32i].
- `core_start` out, NUM_CORES: one-cycle start pulse to all cores.
- `core_abort` out, 1: one-cycle abort pulse.
- `core_found` in, NUM_CORES: one-cycle hit pulse per core.
- `core_nonce` in, 32*NUM_CORES: nonce for each hit, valid with `core_found[i]`.
- `core_done` in, NUM_CORES: level signal; core has finished its range.
- `result_busy` in, 1: downstream cannot accept a result.
- `new_result` out, 1: one-cycle result strobe.
- `result_data` out, 32: nonce, held until the next strobe.
- `running` out, 1: high in RUN state.
- `exhausted` out, 1: one-cycle pulse when all cores are done.
- `dropped` out, 8: count of lost results; saturates at 255.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE. Reset enters IDLE.
- IDLE --new_work--> LOAD. RUN or DONE --new_work--> LOAD; if leaving RUN, `core_abort` pulses in that same cycle.
- LOAD always lasts one cycle. It pulses `core_start` to all cores, then moves to RUN.
- RUN --(&core_done, sampled at least 2 cycles after LOAD)--> DONE, with `exhausted` pulsed once. DONE --new_work--> LOAD.
- On `new_work`:
  - Latch `work_data` into `core_work`.
  - Set `core_nonce_base[i] = i * (2^32 / NUM_CORES)`. For NUM_CORES=1 the base is 0.
  - Clear every pending slot and flush the FIFO.
  - Ignore any `core_found` in the same cycle; those hits belong to the stale job.
- `core_found` is accepted only in RUN and DONE; it is ignored in IDLE and LOAD.
- Pending slots: one slot per core (a valid bit plus a 32-bit nonce). `core_found[i]` fills slot i.
- Pending-slot overflow: if slot i is still valid when core i reports another hit, keep the old nonce, discard the new one and increment `dropped`.
- Arbiter: each cycle, if the FIFO is not full, move one valid slot into the FIFO. The slot is chosen round-robin, starting after the last granted index. A slot may be refilled in the cycle after its grant.
- Full FIFO: pending slots hold their values and no drop occurs. Drops happen only on pending-slot overflow.
- Output: when the FIFO is non-empty, `result_busy`=0 and `new_result` was 0 in the previous cycle, pop the FIFO, pulse `new_result` and drive `result_data` from the popped entry. Strobes are therefore at least 2 cycles apart.
- `dropped` clears only on `rst`; it does not clear on new work.

## Timing
- Reset values:
  - `running`=0, `new_result`=0, `result_data`=0.
  - `core_start`=0, `core_abort`=0, `exhausted`=0.
  - `core_work`=0, `core_nonce_base`=0, `dropped`=0.
  - FIFO empty, pending slots clear, round-robin pointer=0.
- Latency from `new_work` at cycle T:
  - `core_abort` at T, if the FSM was in RUN.
  - `core_work` and `core_nonce_base` valid at T+1.
  - `core_start` at T+1, `running`=1 from T+2.
- Result latency with FIFO empty, no contention and `result_busy`=0: `core_found` at T, slot valid at T+1, FIFO entry at T+2, `new_result` at T+3.
- Simultaneous hits from k cores drain at one per cycle into the FIFO, and leave the FIFO at one per 2 cycles.
- `rst` mid-run: all state returns to reset values at the next edge. No `core_abort` is issued; the cores share `rst`.
- `new_work` in LOAD: restart LOAD with the new data. `core_start` pulses again, with no `core_abort`.

## Test plan
- NUM_CORES=4, `new_work` with `work_data` all 0xA5 bytes -> `core_start`=4'b1111 one cycle later; bases are 0x00000000, 0x40000000, 0x80000000, 0xC0000000; `core_work` matches the input.
- `core_found`=4'b1011 in one cycle with nonces 0x11, 0x22, 0x44 -> three `new_result` strobes, ≥2 cycles apart, in order 0x11, 0x22, 0x44; `dropped`=0.
- `result_busy`=1 while 12 hits arrive from core 0, spaced 3 cycles apart (RESULT_DEPTH=8) -> 8 queued, 1 pending, 3 dropped; `dropped`=3. After releasing busy, exactly 9 results come out.
- During RUN with 2 results queued, pulse `new_work` together with `core_found[2]` -> `core_abort` in the same cycle; no stale results emitted; `core_start` fires next cycle.
- Raise all `core_done` -> exactly one `exhausted` pulse; `running`=0. A following `new_work` restarts LOAD/RUN.
- Assert `rst` for one cycle mid-RUN with the FIFO non-empty -> all outputs are at reset values in the next cycle and no `new_result` follows.
